// File: rtl/approx_mult_err_stats_if.sv
// Sample stream carrying operand pairs and the approximate product under test.
interface approx_mult_err_stats_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] z_apx;

    modport master (output in_valid, x, y, z_apx, input in_ready);
    modport slave  (input in_valid, x, y, z_apx, output in_ready);
endinterface

// File: rtl/approx_mult_err_stats.sv
// Windowed error statistics for an unsigned 8x8 approximate multiplier:
// signed sum, squared sum, max magnitude and inexact count of (x*y - z_apx).
module approx_mult_err_stats #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned ACC_W = 48
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [CNT_W-1:0]          num_samples,
    approx_mult_err_stats_if.slave    s_if,
    output logic                      busy,
    output logic                      done,
    output logic [ACC_W-1:0]          sum_err,
    output logic [ACC_W-1:0]          sum_sq_err,
    output logic [15:0]               max_abs_err,
    output logic [CNT_W-1:0]          err_count
);
    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d, cnt_q, cnt_d;
    logic              drain_q, drain_d;
    logic              accept, clear;

    logic              s1_valid_q, s1_valid_d;
    logic signed [16:0] e_q, e_d;
    logic [15:0]       prod;

    logic              s2_valid_q, s2_valid_d;
    logic signed [16:0] e2_q, e2_d;
    logic [15:0]       a_q, a_d;
    logic [31:0]       s_q, s_d;
    logic              nz_q, nz_d;

    logic [ACC_W-1:0]  sum_q, sum_d, sq_q, sq_d;
    logic [15:0]       max_q, max_d;
    logic [CNT_W-1:0]  ecnt_q, ecnt_d;
    logic [ACC_W:0]    sum_ext, sq_ext;

    assign s_if.in_ready = (state_q == StRun);
    assign accept        = s_if.in_valid && s_if.in_ready;
    assign busy          = (state_q == StRun) || (state_q == StDrain);
    assign done          = (state_q == StDone);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        clear   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    clear = 1'b1;
                    n_d   = num_samples;
                    cnt_d = '0;
                    state_d = (num_samples != '0) ? StRun : StDone;
                end
            end
            StRun: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q + CNT_W'(1) == n_q) begin
                        state_d = StDrain;
                        drain_d = 1'b0;
                    end
                end
            end
            // Two cycles let the last sample clear both pipeline stages.
            StDrain: begin
                if (drain_q) state_d = StDone;
                else         drain_d = 1'b1;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        prod       = 16'(s_if.x) * 16'(s_if.y);
        e_d        = $signed({1'b0, prod}) - $signed({1'b0, s_if.z_apx});
        s1_valid_d = accept;

        s2_valid_d = s1_valid_q;
        e2_d       = e_q;
        a_d        = e_q[16] ? 16'(-e_q) : e_q[15:0];
        s_d        = 32'(a_d) * 32'(a_d);
        nz_d       = (e_q != '0);
    end

    always_comb begin
        sum_ext = {sum_q[ACC_W-1], sum_q} + {{(ACC_W-16){e2_q[16]}}, e2_q};
        sq_ext  = {1'b0, sq_q} + {{(ACC_W-31){1'b0}}, s_q};
        sum_d   = sum_q;
        sq_d    = sq_q;
        max_d   = max_q;
        ecnt_d  = ecnt_q;
        if (clear) begin
            sum_d  = '0;
            sq_d   = '0;
            max_d  = '0;
            ecnt_d = '0;
        end else if (s2_valid_q) begin
            // Sign disagreement between the guard bit and MSB marks overflow.
            if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
                sum_d = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                sum_d = sum_ext[ACC_W-1:0];
            end
            sq_d = sq_ext[ACC_W] ? '1 : sq_ext[ACC_W-1:0];
            if (a_q > max_q) max_d = a_q;
            if (nz_q) ecnt_d = ecnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            n_q        <= '0;
            cnt_q      <= '0;
            drain_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            e_q        <= '0;
            s2_valid_q <= 1'b0;
            e2_q       <= '0;
            a_q        <= '0;
            s_q        <= '0;
            nz_q       <= 1'b0;
            sum_q      <= '0;
            sq_q       <= '0;
            max_q      <= '0;
            ecnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
            s1_valid_q <= s1_valid_d;
            e_q        <= e_d;
            s2_valid_q <= s2_valid_d;
            e2_q       <= e2_d;
            a_q        <= a_d;
            s_q        <= s_d;
            nz_q       <= nz_d;
            sum_q      <= sum_d;
            sq_q       <= sq_d;
            max_q      <= max_d;
            ecnt_q     <= ecnt_d;
        end
    end

    assign sum_err     = sum_q;
    assign sum_sq_err  = sq_q;
    assign max_abs_err = max_q;
    assign err_count   = ecnt_q;
endmodule

// File: tb/tb_approx_mult_err_stats.sv
// Bench for approx_mult_err_stats: directed plan cases plus random windows
// scored against an arithmetic reference model.
module tb_approx_mult_err_stats;
    localparam int CNT_W = 16;
    localparam int ACC_W = 34;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             busy, done;
    logic [ACC_W-1:0] sum_err, sum_sq_err;
    logic [15:0]      max_abs_err;
    logic [CNT_W-1:0] err_count;

    approx_mult_err_stats_if s_if ();

    approx_mult_err_stats #(.CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_samples (num_samples),
        .s_if        (s_if),
        .busy        (busy),
        .done        (done),
        .sum_err     (sum_err),
        .sum_sq_err  (sum_sq_err),
        .max_abs_err (max_abs_err),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0]  qx[$];
    logic [7:0]  qy[$];
    logic [15:0] qz[$];
    int vmode;
    int vpat[$];
    int mid_start_cyc;

    longint m_sum, m_sq, m_max;
    int     m_cnt;

    int     r_accepts, r_done_lat, r_done_cyc;
    bit     r_ready_after, r_ready_ever, r_busy_bad, r_after_ok, r_timeout;
    longint r_sum, r_sq, r_max;
    int     r_cnt;

    function automatic void model_add(input int x, input int y, input int z);
        longint e, ae;
        longint hi, lo, sq_max;
        hi     = (longint'(1) << (ACC_W - 1)) - 1;
        lo     = -(longint'(1) << (ACC_W - 1));
        sq_max = (longint'(1) << ACC_W) - 1;
        e  = longint'(x * y) - longint'(z);
        ae = (e < 0) ? -e : e;
        m_sum = m_sum + e;
        if (m_sum > hi) m_sum = hi;
        if (m_sum < lo) m_sum = lo;
        m_sq = m_sq + e * e;
        if (m_sq > sq_max) m_sq = sq_max;
        if (ae > m_max) m_max = ae;
        if (e != 0) m_cnt++;
    endfunction

    task automatic gen_random(input int n);
        int x, y, p, z;
        qx.delete(); qy.delete(); qz.delete();
        for (int i = 0; i < n; i++) begin
            x = $urandom_range(0, 255);
            y = $urandom_range(0, 255);
            p = x * y;
            case ($urandom_range(0, 2))
                0:       z = p;
                1:       z = $urandom_range(0, 65535);
                default: begin
                    z = p + $urandom_range(0, 64) - 32;
                    if (z < 0) z = 0;
                    if (z > 65535) z = 65535;
                end
            endcase
            qx.push_back(8'(x));
            qy.push_back(8'(y));
            qz.push_back(16'(z));
        end
    endtask

    // Runs one window from the current negedge and records what was observed.
    task automatic run_window(input int n);
        int idx, cyc, since, budget, k;
        bit fin, v;
        m_sum = 0; m_sq = 0; m_max = 0; m_cnt = 0;
        r_accepts = 0; r_done_lat = -1; r_done_cyc = -1;
        r_ready_after = 0; r_ready_ever = 0; r_busy_bad = 0; r_after_ok = 0; r_timeout = 0;
        r_sum = 0; r_sq = 0; r_max = 0; r_cnt = 0;
        start = 1'b1;
        num_samples = CNT_W'(n);
        s_if.in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        idx = 0; cyc = 0; since = -1; k = 0; fin = 0;
        budget = 30 * n + 40;
        while (!fin && cyc < budget) begin
            if (done) begin
                r_done_lat = since;
                r_done_cyc = cyc;
                r_sum = longint'($signed(sum_err));
                r_sq  = longint'(sum_sq_err);
                r_max = longint'(max_abs_err);
                r_cnt = int'(err_count);
                fin = 1;
            end else if (n > 0 && !busy) begin
                r_busy_bad = 1;
            end
            if (s_if.in_ready) begin
                r_ready_ever = 1;
                if (since >= 0) r_ready_after = 1;
            end
            start = !fin && (cyc == mid_start_cyc);
            if (!fin && idx < n) begin
                case (vmode)
                    0:       v = 1'b1;
                    1:       v = (k < vpat.size()) ? (vpat[k] != 0) : 1'b1;
                    default: v = ($urandom_range(0, 3) != 0);
                endcase
                k++;
                s_if.in_valid = v;
                s_if.x = qx[idx];
                s_if.y = qy[idx];
                s_if.z_apx = qz[idx];
            end else begin
                s_if.in_valid = 1'b0;
            end
            if (s_if.in_valid && s_if.in_ready) begin
                model_add(int'(qx[idx]), int'(qy[idx]), int'(qz[idx]));
                idx++;
                r_accepts++;
                if (idx == n) since = 0;
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
                if (since >= 0) since++;
            end
        end
        start = 1'b0;
        s_if.in_valid = 1'b0;
        if (!fin) begin
            r_timeout = 1;
        end else begin
            @(negedge clk);
            r_after_ok = !done && !busy && !s_if.in_ready;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({s_if.in_ready, busy, done} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got ready/busy/done=%b expected 000", {s_if.in_ready, busy, done});
        end
        tests_run++;
        if (sum_err !== '0 || sum_sq_err !== '0 || max_abs_err !== '0 || err_count !== '0) begin
            tests_failed++;
            $display("FAIL reset_results: got %0h %0h %0h %0h expected all 0",
                     sum_err, sum_sq_err, max_abs_err, err_count);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        qx = '{8'd3, 8'd255}; qy = '{8'd5, 8'd255}; qz = '{16'd12, 16'd65024};
        vmode = 0; mid_start_cyc = -1;
        run_window(2);
        tests_run++;
        if (r_timeout !== 1'b0) begin tests_failed++; $display("FAIL basic_timeout: got 1 expected 0"); end
        tests_run++;
        if (r_sum !== 64'sd4) begin tests_failed++; $display("FAIL basic_sum: got %0d expected 4", r_sum); end
        tests_run++;
        if (r_sq !== 64'sd10) begin tests_failed++; $display("FAIL basic_sq: got %0d expected 10", r_sq); end
        tests_run++;
        if (r_max !== 64'sd3) begin tests_failed++; $display("FAIL basic_max: got %0d expected 3", r_max); end
        tests_run++;
        if (r_cnt !== 2) begin tests_failed++; $display("FAIL basic_cnt: got %0d expected 2", r_cnt); end
        tests_run++;
        if (r_done_lat !== 3) begin tests_failed++; $display("FAIL basic_done_lat: got %0d expected 3", r_done_lat); end
        tests_run++;
        if (r_ready_after !== 1'b0) begin tests_failed++; $display("FAIL basic_ready_after: got 1 expected 0"); end
        tests_run++;
        if (r_after_ok !== 1'b1 || r_busy_bad !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_pulse: got after_ok=%0b busy_bad=%0b expected 1 0", r_after_ok, r_busy_bad);
        end
    endtask

    task automatic test_exact;
        qx = '{8'd0, 8'd17, 8'd200}; qy = '{8'd0, 8'd13, 8'd100}; qz = '{16'd0, 16'd221, 16'd20000};
        vmode = 0; mid_start_cyc = -1;
        run_window(3);
        tests_run++;
        if (r_timeout !== 1'b0 || r_after_ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL exact_done: got timeout=%0b after_ok=%0b expected 0 1", r_timeout, r_after_ok);
        end
        tests_run++;
        if (r_sum !== 0 || r_sq !== 0 || r_max !== 0 || r_cnt !== 0) begin
            tests_failed++;
            $display("FAIL exact_results: got %0d %0d %0d %0d expected 0 0 0 0", r_sum, r_sq, r_max, r_cnt);
        end
    endtask

    task automatic test_negative;
        qx = '{8'd0}; qy = '{8'd0}; qz = '{16'd65535};
        vmode = 0; mid_start_cyc = -1;
        run_window(1);
        tests_run++;
        if (r_sum !== -64'sd65535) begin tests_failed++; $display("FAIL neg_sum: got %0d expected -65535", r_sum); end
        tests_run++;
        if (r_sq !== 64'sd4294836225) begin tests_failed++; $display("FAIL neg_sq: got %0d expected 4294836225", r_sq); end
        tests_run++;
        if (r_max !== 64'sd65535 || r_cnt !== 1) begin
            tests_failed++;
            $display("FAIL neg_max_cnt: got %0d %0d expected 65535 1", r_max, r_cnt);
        end
        tests_run++;
        if (r_done_lat !== 3) begin tests_failed++; $display("FAIL neg_done_lat: got %0d expected 3", r_done_lat); end
    endtask

    task automatic test_zero;
        vmode = 0; mid_start_cyc = -1;
        run_window(0);
        tests_run++;
        if (r_done_cyc !== 0) begin tests_failed++; $display("FAIL zero_done_cyc: got %0d expected 0", r_done_cyc); end
        tests_run++;
        if (r_sum !== 0 || r_sq !== 0 || r_max !== 0 || r_cnt !== 0) begin
            tests_failed++;
            $display("FAIL zero_results: got %0d %0d %0d %0d expected 0 0 0 0", r_sum, r_sq, r_max, r_cnt);
        end
        tests_run++;
        if (r_ready_ever !== 1'b0) begin tests_failed++; $display("FAIL zero_ready: got 1 expected 0"); end
    endtask

    task automatic test_gaps;
        gen_random(4);
        vmode = 1; vpat = '{1, 0, 0, 1, 1, 0, 1}; mid_start_cyc = 2;
        run_window(4);
        tests_run++;
        if (r_accepts !== 4 || r_timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL gaps_accepts: got %0d timeout=%0b expected 4 0", r_accepts, r_timeout);
        end
        tests_run++;
        if (r_sum !== m_sum || r_sq !== m_sq || r_max !== m_max || r_cnt !== m_cnt) begin
            tests_failed++;
            $display("FAIL gaps_results: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                     r_sum, r_sq, r_max, r_cnt, m_sum, m_sq, m_max, m_cnt);
        end
        tests_run++;
        if (r_done_lat !== 3 || r_busy_bad !== 1'b0) begin
            tests_failed++;
            $display("FAIL gaps_timing: got lat=%0d busy_bad=%0b expected 3 0", r_done_lat, r_busy_bad);
        end
        mid_start_cyc = -1; vmode = 0;
    endtask

    task automatic test_reset_mid;
        int acc, cyc;
        bit saw_done;
        start = 1'b1;
        num_samples = CNT_W'(5);
        @(negedge clk);
        start = 1'b0;
        acc = 0; cyc = 0;
        while (acc < 2 && cyc < 20) begin
            s_if.in_valid = 1'b1;
            s_if.x = 8'd10; s_if.y = 8'd10; s_if.z_apx = 16'd0;
            if (s_if.in_ready) acc++;
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (acc !== 2) begin tests_failed++; $display("FAIL rstmid_accepts: got %0d expected 2", acc); end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({s_if.in_ready, busy, done} !== 3'b000) begin
            tests_failed++;
            $display("FAIL rstmid_ctrl: got ready/busy/done=%b expected 000", {s_if.in_ready, busy, done});
        end
        tests_run++;
        if (sum_err !== '0 || sum_sq_err !== '0 || max_abs_err !== '0 || err_count !== '0) begin
            tests_failed++;
            $display("FAIL rstmid_results: got %0h %0h %0h %0h expected all 0",
                     sum_err, sum_sq_err, max_abs_err, err_count);
        end
        rst = 1'b0;
        s_if.in_valid = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        tests_run++;
        if (saw_done !== 1'b0) begin tests_failed++; $display("FAIL rstmid_no_done: got 1 expected 0"); end
        gen_random(5);
        run_window(5);
        tests_run++;
        if (r_sum !== m_sum || r_sq !== m_sq || r_max !== m_max || r_cnt !== m_cnt || r_timeout) begin
            tests_failed++;
            $display("FAIL rstmid_rerun: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                     r_sum, r_sq, r_max, r_cnt, m_sum, m_sq, m_max, m_cnt);
        end
    endtask

    task automatic test_back_to_back;
        for (int w = 0; w < 2; w++) begin
            gen_random(3 + w);
            run_window(3 + w);
            tests_run++;
            if (r_sum !== m_sum || r_sq !== m_sq || r_max !== m_max || r_cnt !== m_cnt
                || r_done_lat !== 3) begin
                tests_failed++;
                $display("FAIL b2b_%0d: got %0d %0d %0d %0d lat=%0d expected %0d %0d %0d %0d lat=3",
                         w, r_sum, r_sq, r_max, r_cnt, r_done_lat, m_sum, m_sq, m_max, m_cnt);
            end
        end
    endtask

    task automatic test_random;
        int n;
        vmode = 2; mid_start_cyc = -1;
        for (int w = 0; w < 10; w++) begin
            n = $urandom_range(1, 12);
            gen_random(n);
            run_window(n);
            tests_run++;
            if (r_sum !== m_sum || r_sq !== m_sq || r_max !== m_max || r_cnt !== m_cnt) begin
                tests_failed++;
                $display("FAIL random_%0d: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                         w, r_sum, r_sq, r_max, r_cnt, m_sum, m_sq, m_max, m_cnt);
            end
            tests_run++;
            if (r_done_lat !== 3 || r_ready_after !== 1'b0 || r_after_ok !== 1'b1) begin
                tests_failed++;
                $display("FAIL random_timing_%0d: got lat=%0d ready_after=%0b after_ok=%0b expected 3 0 1",
                         w, r_done_lat, r_ready_after, r_after_ok);
            end
        end
        vmode = 0;
    endtask

    task automatic test_sq_saturation;
        qx.delete(); qy.delete(); qz.delete();
        for (int i = 0; i < 6; i++) begin
            qx.push_back(8'd0); qy.push_back(8'd0); qz.push_back(16'd65535);
        end
        vmode = 0; mid_start_cyc = -1;
        run_window(6);
        tests_run++;
        if (r_sq !== 64'sd17179869183) begin
            tests_failed++;
            $display("FAIL sat_sq: got %0d expected 17179869183", r_sq);
        end
        tests_run++;
        if (r_sum !== -64'sd393210 || r_max !== 64'sd65535 || r_cnt !== 6) begin
            tests_failed++;
            $display("FAIL sat_other: got %0d %0d %0d expected -393210 65535 6", r_sum, r_max, r_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        num_samples = '0;
        s_if.in_valid = 1'b0;
        s_if.x = '0;
        s_if.y = '0;
        s_if.z_apx = '0;
        vmode = 0;
        mid_start_cyc = -1;
        repeat (2) @(negedge clk);
        test_reset;
        test_basic;
        test_exact;
        test_negative;
        test_zero;
        test_gaps;
        test_reset_mid;
        test_back_to_back;
        test_random;
        test_sq_saturation;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/approx_mult_err_stats.md
Name: approx_mult_err_stats

Overview:
- Streaming error-statistics collector placed directly downstream of an unsigned 8x8 approximate multiplier.
- Consumes operand pairs (x, y) together with the multiplier's approximate product z_apx.
- Computes the exact product internally and accumulates signed error, squared (L2) error, maximum absolute error and the count of inexact samples over a programmed window.
- Used in characterisation benches and on-chip self-check to score multiplier variants.

Parameters:
- CNT_W, 16: width of sample counter; window length 1 .. 2^CNT_W-1.
- ACC_W, 48: width of the sum_err (signed) and sum_sq_err (unsigned) accumulators; legal range 34..64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle request to begin a window; honoured only in IDLE
- num_samples  input  CNT_W  window length; sampled on the accepted start
- in_valid  input  1  sample valid
- in_ready  output  1  block accepts a sample this cycle
- x  input  8  operand x (unsigned)
- y  input  8  operand y (unsigned)
- z_apx  input  16  approximate product for (x, y)
- busy  output  1  high in RUN and DRAIN
- done  output  1  one-cycle pulse; results final
- sum_err  output  ACC_W  signed saturating sum of (x*y - z_apx)
- sum_sq_err  output  ACC_W  unsigned saturating sum of (x*y - z_apx)^2
- max_abs_err  output  16  maximum of |x*y - z_apx| over the window
- err_count  output  CNT_W  number of samples with nonzero error

Behaviour:
- Reset (synchronous, active-high): state IDLE, in_ready=0, busy=0, done=0, all results 0, pipeline valids 0. Reset mid-window aborts without a done pulse.
- Transfer rule: a sample is accepted on a rising edge with in_valid=1 and in_ready=1. x, y and z_apx must be stable only in that cycle.
- States: IDLE, RUN, DRAIN, DONE_S.
- IDLE:
  - in_ready=0.
  - start=1 with num_samples>0: latch N, clear all result registers, go to RUN.
  - start=1 with num_samples=0: clear results, go to DONE_S.
- RUN:
  - in_ready=1.
  - The accept that brings the accepted-count to N moves the FSM to DRAIN. in_ready=0 from the next cycle onward.
- DRAIN:
  - in_ready=0.
  - Lasts exactly 2 cycles (pipeline depth), then go to DONE_S.
- DONE_S:
  - done=1 for this single cycle, then go to IDLE.
  - Results hold until the next accepted start.
- start outside IDLE is ignored. start and rst together: rst wins.
- Pipeline, for a sample accepted at edge t:
  - Stage 1, registered at t: p = x*y (16 b unsigned); e = p - z_apx (17 b signed, range -65535..65025).
  - Stage 2, registered at t+1: a = |e| (16 b); s = e*e (32 b unsigned, exact); nz = (e != 0).
  - Stage 3, updates at edge t+2:
    - sum_err += sign-extended e;
    - sum_sq_err += s;
    - max_abs_err = max(max_abs_err, a);
    - err_count += nz.
- Saturation:
  - sum_err clamps at +(2^(ACC_W-1)-1) and -2^(ACC_W-1).
  - sum_sq_err clamps at 2^ACC_W-1 and sticks once reached.
  - err_count cannot overflow because it is at most N.
- Timing: last sample accepted at edge T; final accumulate at T+2; done high in the cycle after edge T+2; IDLE after edge T+3.
- Back-to-back: start may be asserted in the first IDLE cycle after done.
- Gaps (in_valid=0) during RUN stall acceptance only. The pipeline keeps draining, and bubbles carry valid=0 and do not accumulate.

Test Plan:
- N=2. Samples (x=3, y=5, z_apx=12) then (x=255, y=255, z_apx=65024), back-to-back -> sum_err=4, sum_sq_err=10, max_abs_err=3, err_count=2. done exactly 3 cycles after the 2nd accept edge counts as DONE_S cycle; in_ready=0 after the 2nd accept.
- N=3, exact products: (0,0,0), (17,13,221), (200,100,20000) -> all results 0, err_count=0, done pulses once.
- Negative and large error: N=1, (x=0, y=0, z_apx=65535) -> sum_err=-65535, sum_sq_err=4294836225, max_abs_err=65535.
- Handshake gaps: N=4 with in_valid toggling 1,0,0,1,1,0,1 -> exactly 4 accepts, results equal the gap-free run; start pulsed mid-RUN is ignored.
- num_samples=0 -> done one cycle after start, all results 0, in_ready never high.
- Reset: rst asserted after 2 of 5 samples -> next cycle in_ready=0, busy=0, all results 0, no done. A new start afterwards runs cleanly.
